psum_accum_wb: RTL and testbench

- Downstream stage of the PE group.
- Consumes the 19-bit signed group sums produced with their write-back strobe, and accumulates acc_len sums per output pixel on top of a bias.
- Requantizes each pixel result (arithmetic shift, optional ReLU, saturate to int8) and writes it into the output feature-map buffer through a valid/ready port with an auto-incrementing address.
- Signals layer completion with a done pulse.

---
 rtl/psum_accum_wb.sv | 153 +++++++++++++++
 tb/tb_psum_accum_wb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum_wb.sv
// psum_accum_wb: accumulates acc_len signed group sums per output pixel on
// top of a bias, requantizes to int8 and writes each pixel through a
// valid/ready port with an auto-incrementing address.
// Optional build macro: PSUM_ROUND_EN (round-half-up before the right shift).
module psum_accum_wb #(
  parameter int IN_W   = 19,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        acc_len,
  input  logic [ADDR_W-1:0] out_count,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       bias,
  input  logic [3:0]        shift,
  input  logic              relu_on,
  input  logic              psum_valid,
  input  logic [IN_W-1:0]   psum_in,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t state, state_nx;

  logic [7:0]               len_m1;
  logic [ADDR_W-1:0]        cnt_q;
  logic [15:0]              bias_q;
  logic [3:0]               shift_q;
  logic                     relu_q;
  logic signed [ACC_W-1:0]  acc;
  logic [7:0]               beat;
  logic [ADDR_W-1:0]        pixel;

  logic                     fire, last, accept, layer_end;
  logic signed [ACC_W:0]    sum_full;
  logic signed [ACC_W-1:0]  sum_sat, pre_shift, shr;
  logic [ACC_W:0]           rnd;
  logic [OUT_W-1:0]         q_pix;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
    if (x[ACC_W] != x[ACC_W-1])
      sat_acc = x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_acc = x[ACC_W-1:0];
  endfunction

  assign fire      = (state == S_RUN) && psum_valid;
  assign last      = fire && (beat == len_m1);
  assign accept    = wr_en && wr_ready;
  assign layer_end = last && ((pixel + 1'b1) == cnt_q);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Saturating accumulate and requantize of the current beat
  always_comb begin
    rnd       = '0;
    sum_full  = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){psum_in[IN_W-1]}}, psum_in};
    sum_sat   = sat_acc(sum_full);
`ifdef PSUM_ROUND_EN
    if (shift_q != 4'd0) rnd = (ACC_W+1)'(1) << (shift_q - 4'd1);
    pre_shift = sat_acc({sum_sat[ACC_W-1], sum_sat} + rnd);
`else
    pre_shift = sum_sat;
`endif
    shr = pre_shift >>> shift_q;
    if (relu_q && shr[ACC_W-1]) shr = '0;
    if (shr[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){shr[ACC_W-1]}})
      q_pix = shr[OUT_W-1:0];
    else
      q_pix = shr[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; FLUSH leaves on the edge that accepts the final write
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (out_count == '0) ? S_DONE : S_RUN;
      S_RUN:   if (layer_end) state_nx = S_FLUSH;
      S_FLUSH: if (!wr_en || wr_ready) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Config latch, accumulator, counters and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_m1  <= '0;
      cnt_q   <= '0;
      bias_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      acc     <= '0;
      beat    <= '0;
      pixel   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      overrun <= 1'b0;
    end else if (state == S_IDLE && start) begin
      len_m1  <= (acc_len == 8'd0) ? 8'd0 : acc_len - 8'd1;
      cnt_q   <= out_count;
      bias_q  <= bias;
      shift_q <= shift;
      relu_q  <= relu_on;
      acc     <= {{(ACC_W-16){bias[15]}}, bias};
      beat    <= '0;
      pixel   <= '0;
      wr_addr <= base_addr;
      overrun <= 1'b0;
    end else begin
      if (fire) begin
        if (last) begin
          acc   <= {{(ACC_W-16){bias_q[15]}}, bias_q};
          beat  <= '0;
          pixel <= pixel + 1'b1;
        end else begin
          acc   <= sum_sat;
          beat  <= beat + 8'd1;
        end
      end
      if (accept) wr_addr <= wr_addr + 1'b1;
      // A new pixel may load only into an empty register or one draining this edge
      if (last) begin
        if (!wr_en || accept) begin
          wr_en   <= 1'b1;
          wr_data <= q_pix;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_wb.sv
// Self-checking bench for psum_accum_wb: directed cases plus randomized layers
// checked against an arithmetic reference model of the pixel results.
module tb_psum_accum_wb;
  localparam int IN_W = 19, ACC_W = 24, OUT_W = 8, ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst, start, relu_on, psum_valid, wr_ready;
  logic [7:0]        acc_len;
  logic [ADDR_W-1:0] out_count, base_addr;
  logic [15:0]       bias;
  logic [3:0]        shift;
  logic [IN_W-1:0]   psum_in;
  logic              wr_en, busy, done, overrun;
  logic [ADDR_W-1:0] wr_addr;
  logic [OUT_W-1:0]  wr_data;

  psum_accum_wb #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_len(acc_len), .out_count(out_count),
    .base_addr(base_addr), .bias(bias), .shift(shift), .relu_on(relu_on),
    .psum_valid(psum_valid), .psum_in(psum_in), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int gcyc = 0, done_cnt = 0, done_cyc = -1, last_wr_cyc = -1, last_ps_cyc = -1;
  int got_a[$], got_d[$], got_c[$], exp_d[$], ps_q[$];
  logic hold = 1'b0;
  int hold_a, hold_d;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat24(input longint x);
    if (x > 64'sd8388607)  return 64'sd8388607;
    if (x < -64'sd8388608) return -64'sd8388608;
    return x;
  endfunction

  function automatic int requant(input longint s, input int sh, input int relu);
    longint r;
`ifdef PSUM_ROUND_EN
    if (sh > 0) s = sat24(s + (longint'(1) << (sh - 1)));
`endif
    r = s >>> sh;
    if (relu != 0 && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  function automatic int rand_ps();
    logic [IN_W-1:0] t;
    t = IN_W'($urandom);
    return int'($signed(t));
  endfunction

  // Drive one cycle's inputs, observe the outputs settled since the last edge
  task automatic cycle(input logic v, input int ps, input logic rdy);
    logic [31:0] pv;
    pv = ps;
    psum_valid = v; psum_in = pv[IN_W-1:0]; wr_ready = rdy;
    if (hold) begin
      chk("hold_en", int'(wr_en), 1);
      chk("hold_addr", int'(wr_addr), hold_a);
      chk("hold_data", int'($signed(wr_data)), hold_d);
    end
    if (wr_en && rdy) begin
      got_a.push_back(int'(wr_addr));
      got_d.push_back(int'($signed(wr_data)));
      got_c.push_back(gcyc);
      last_wr_cyc = gcyc;
    end
    hold   = wr_en && !rdy;
    hold_a = int'(wr_addr);
    hold_d = int'($signed(wr_data));
    if (done) begin done_cnt++; done_cyc = gcyc; end
    gcyc++;
    @(negedge clk);
  endtask

  // rmode: 0 ready always, 1 random ready, 2 ready low for the first 3 cycles
  // pace: random gaps, and never present a pixel's last beat into a stalled register
  task automatic run_layer(input int len, input int cnt, input int base, input int bias_v,
                           input int shift_v, input int relu_v, input int rmode, input bit pace);
    int le, idx, cyc, budget, n0;
    logic v, rdy, lst;
    longint acc;
    logic [31:0] bv;
    le = (len == 0) ? 1 : len;
    exp_d.delete();
    for (int p = 0; p < cnt; p++) begin
      acc = bias_v;
      for (int b = 0; b < le; b++) acc = sat24(acc + ps_q[p*le + b]);
      exp_d.push_back(requant(acc, shift_v, relu_v));
    end
    got_a.delete(); got_d.delete(); got_c.delete();
    done_cnt = 0; done_cyc = -1; hold = 1'b0;
    bv = bias_v;
    acc_len = 8'(len); out_count = ADDR_W'(cnt); base_addr = ADDR_W'(base);
    bias = bv[15:0]; shift = 4'(shift_v); relu_on = (relu_v != 0);
    start = 1'b1;
    cycle(1'b0, 0, 1'b1);
    start = 1'b0;
    chk("busy_run", int'(busy), 1);
    // Scramble config inputs; the block must use its latched copy
    acc_len = 8'($urandom); out_count = ADDR_W'($urandom); base_addr = ADDR_W'($urandom);
    bias = 16'($urandom); shift = 4'($urandom); relu_on = 1'($urandom);
    idx = 0; cyc = 0;
    while (idx < ps_q.size()) begin
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom) : (cyc < 3) ? 1'b0 : 1'b1;
      lst = ((idx % le) == le - 1);
      v = pace ? ($urandom_range(3) != 0) : 1'b1;
      if (pace && lst && wr_en && !rdy) v = 1'b0;
      if (v) last_ps_cyc = gcyc;
      cycle(v, v ? ps_q[idx] : rand_ps(), rdy);
      if (v) idx++;
      cyc++;
    end
    budget = 0;
    while (done_cnt == 0 && budget < 300) begin
      rdy = (rmode == 1) ? 1'($urandom) : 1'b1;
      cycle(1'b0, 0, rdy);
      budget++;
    end
    chk("done_seen", done_cnt, 1);
    chk("busy_after", int'(busy), 0);
    n0 = got_a.size();
    repeat (3) cycle(1'b1, rand_ps(), 1'b1);
    chk("done_once", done_cnt, 1);
    chk("idle_writes", got_a.size() - n0, 0);
    for (int i = 0; i < 3; i++) begin
      if (got_a.size() > n0) begin void'(got_a.pop_back()); void'(got_d.pop_back()); end
    end
  endtask

  task automatic check_writes(input int base);
    chk("n_writes", got_a.size(), exp_d.size());
    for (int i = 0; i < got_a.size() && i < exp_d.size(); i++) begin
      chk("wr_addr", got_a[i], (base + i) % (1 << ADDR_W));
      chk("wr_data", got_d[i], exp_d[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; relu_on = 1'b0; psum_valid = 1'b0; wr_ready = 1'b0;
    acc_len = '0; out_count = '0; base_addr = '0; bias = '0; shift = '0; psum_in = '0;
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_addr", int'(wr_addr), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic accumulation, latency and done timing
    ps_q = '{5, -3, 100};
    run_layer(3, 1, 5, 10, 0, 0, 0, 1'b0);
    check_writes(5);
    chk("t1_data", (got_d.size() > 0) ? got_d[0] : -999, 112);
    chk("t1_latency", last_wr_cyc - last_ps_cyc, 1);
    chk("t1_done_gap", done_cyc - last_wr_cyc, 1);

    // Int8 saturation both ways
    ps_q = '{200, 200};
    run_layer(2, 1, 0, 0, 0, 0, 0, 1'b0);
    chk("sat_pos", (got_d.size() > 0) ? got_d[0] : -999, 127);
    ps_q = '{-200, -200};
    run_layer(2, 1, 0, 0, 0, 0, 0, 1'b0);
    chk("sat_neg", (got_d.size() > 0) ? got_d[0] : -999, -128);

    // ReLU
    ps_q = '{10};
    run_layer(1, 1, 0, -50, 0, 1, 0, 1'b0);
    chk("relu_on", (got_d.size() > 0) ? got_d[0] : -999, 0);
    run_layer(1, 1, 0, -50, 0, 0, 0, 1'b0);
    chk("relu_off", (got_d.size() > 0) ? got_d[0] : -999, -40);

    // Shift with/without rounding
    ps_q = '{0};
    run_layer(1, 1, 0, 100, 3, 0, 0, 1'b0);
`ifdef PSUM_ROUND_EN
    chk("shift_pos", (got_d.size() > 0) ? got_d[0] : -999, 13);
`else
    chk("shift_pos", (got_d.size() > 0) ? got_d[0] : -999, 12);
`endif
    run_layer(1, 1, 0, -100, 3, 0, 0, 1'b0);
`ifdef PSUM_ROUND_EN
    chk("shift_neg", (got_d.size() > 0) ? got_d[0] : -999, -12);
`else
    chk("shift_neg", (got_d.size() > 0) ? got_d[0] : -999, -13);
`endif

    // Accumulator saturation: 40 max beats then 40 min beats
    ps_q.delete();
    for (int i = 0; i < 40; i++) ps_q.push_back(262143);
    for (int i = 0; i < 40; i++) ps_q.push_back(-262144);
    run_layer(80, 1, 3, 0, 15, 0, 0, 1'b0);
    check_writes(3);

    // Back-to-back writes across the address wrap
    ps_q = '{rand_ps(), rand_ps(), rand_ps()};
    run_layer(1, 3, 1022, 7, 4, 0, 0, 1'b0);
    check_writes(1022);
    chk("b2b_span", (got_c.size() == 3) ? got_c[2] - got_c[0] : -1, 2);
    chk("b2b_overrun", int'(overrun), 0);

    // Stalled output register drops later pixels and flags overrun
    ps_q = '{rand_ps(), rand_ps(), rand_ps()};
    run_layer(1, 3, 40, 0, 2, 0, 2, 1'b0);
    chk("ovr_nwr", got_a.size(), 1);
    chk("ovr_addr", (got_a.size() > 0) ? got_a[0] : -1, 40);
    chk("ovr_data", (got_d.size() > 0) ? got_d[0] : -999, exp_d[0]);
    chk("ovr_flag", int'(overrun), 1);

    // Reset mid-layer
    acc_len = 8'd1; out_count = 10'd4; base_addr = 10'd7; bias = '0; shift = '0; relu_on = 1'b0;
    start = 1'b1;
    cycle(1'b0, 0, 1'b0);
    start = 1'b0;
    cycle(1'b1, 5, 1'b0);
    cycle(1'b1, 6, 1'b0);
    cycle(1'b1, 7, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_addr", int'(wr_addr), 0);
    chk("mid_rst_data", int'(wr_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    @(negedge clk);
    rst = 1'b0; hold = 1'b0; done_cnt = 0; got_a.delete(); got_d.delete(); got_c.delete();
    repeat (4) cycle(1'b1, 1, 1'b1);
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_no_wr", got_a.size(), 0);

    // Empty layer: done only
    ps_q.delete();
    run_layer(2, 0, 9, 0, 0, 0, 0, 1'b0);
    chk("empty_nwr", got_a.size(), 0);

    // Randomized layers against the reference model
    for (int t = 0; t < 8; t++) begin
      int len, cnt, base, bv, sh, rl, le;
      len  = $urandom_range(6);
      cnt  = $urandom_range(1, 8);
      base = $urandom_range(1023);
      bv   = int'($signed(16'($urandom)));
      sh   = $urandom_range(15);
      rl   = $urandom_range(1);
      le   = (len == 0) ? 1 : len;
      ps_q.delete();
      for (int i = 0; i < le * cnt; i++) ps_q.push_back(rand_ps());
      run_layer(len, cnt, base, bv, sh, rl, 1, 1'b1);
      check_writes(base);
      chk("rnd_overrun", int'(overrun), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
